// File: rtl/uart_rcv.sv
// rtl/uart_rcv.sv - 8N1 UART receiver with mid-bit sampling, ready flag and framing-error flag
module uart_rcv #(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frame_err
);

  typedef enum logic {IDLE, RECV} state_t;

  localparam logic [15:0] FULL_BIT = 16'(BAUD_DIV);
  localparam logic [15:0] HALF_BIT = 16'(BAUD_DIV / 2);

  state_t      state;
  logic        rx_m;
  logic        rx_s;
  logic [15:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic [8:0]  sh;
  logic        done;

  assign rx_data = sh[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      sh        <= 9'h1FF;
      done      <= 1'b0;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= RECV;
            baud_cnt <= HALF_BIT;
            bit_cnt  <= '0;
          end
        end
        RECV: begin
          // A count of 1 is the cycle on which the decrement would land on 0.
          if (baud_cnt == 16'd1) begin
            baud_cnt <= FULL_BIT;
            sh       <= {rx_s, sh[8:1]};
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd9) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase

      // Completion wins over acknowledge and over a start detected on the same edge.
      if (done) begin
        rdy       <= 1'b1;
        frame_err <= ~sh[8];
      end else if (clr_rdy || (state == IDLE && !rx_s)) begin
        rdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rcv.sv
// tb/tb_uart_rcv.sv - directed and random frame bench for uart_rcv with scoreboard
module tb_uart_rcv;

  localparam int BIT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       RX;
  logic       clr_man;
  logic       tie;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frame_err;

  int total = 0;
  int bad   = 0;
  int rises = 0;
  logic [8:0] exp_q[$];

  assign clr_rdy = tie ? rdy : clr_man;

  uart_rcv #(.BAUD_DIV(BIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .RX        (RX),
    .clr_rdy   (clr_rdy),
    .rx_data   (rx_data),
    .rdy       (rdy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drives one frame starting at a falling clock edge; expected {frame_err, data} is queued first.
  task automatic send_byte(input logic [7:0] d, input logic stop, input logic push);
    if (push) exp_q.push_back({~stop, d});
    RX = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      repeat (BIT) @(negedge clk);
    end
    RX = stop;
    repeat (BIT) @(negedge clk);
    RX = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 20 * BIT) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check(tag, exp_q.size(), 0);
  endtask

  // Scoreboard: every rising edge of rdy must consume exactly one queued frame.
  always @(negedge clk) begin
    static logic rdy_q = 1'b0;
    logic [8:0] e;
    if (rdy && !rdy_q) begin
      rises++;
      check("rdy_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rx_data", rx_data, e[7:0]);
        check("frame_err", frame_err, e[8]);
      end
    end
    if (tie && rdy) check("rdy_width", rdy_q, 0);
    rdy_q = rdy;
  end

  initial begin
    int cycles;
    int hold_ok;
    int rises_before;

    rst = 1'b1; RX = 1'b1; clr_man = 1'b0; tie = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_rdy", rdy, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_rx_data", rx_data, 8'hFF);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Single byte held until acknowledged; rdy after half bit + 9 bits + pipeline delay.
    cycles = 0;
    fork
      send_byte(8'hA5, 1'b1, 1'b1);
      begin
        do begin
          @(posedge clk); #1;
          cycles++;
        end while (!rdy && cycles < 400);
      end
    join
    check("latency_window", (cycles >= BIT/2 + 9*BIT + 3) && (cycles <= BIT/2 + 9*BIT + 5), 1);
    hold_ok = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rdy !== 1'b1) hold_ok = 0;
    end
    check("rdy_held", hold_ok, 1);
    clr_man = 1'b1;
    @(negedge clk);
    clr_man = 1'b0;
    @(negedge clk);
    check("rdy_cleared", rdy, 0);
    drain("drain_a5");

    // Back-to-back bytes with rdy acknowledged by itself.
    tie = 1'b1;
    rises_before = rises;
    send_byte(8'h00, 1'b1, 1'b1);
    send_byte(8'hFF, 1'b1, 1'b1);
    send_byte(8'h3C, 1'b1, 1'b1);
    repeat (2 * BIT) @(negedge clk);
    drain("drain_b2b");
    check("b2b_pulses", rises - rises_before, 3);

    // Low stop bit, immediately followed by a good frame.
    rises_before = rises;
    send_byte(8'h81, 1'b0, 1'b1);
    send_byte(8'h7E, 1'b1, 1'b1);
    repeat (2 * BIT) @(negedge clk);
    drain("drain_ferr");
    check("ferr_pulses", rises - rises_before, 2);

    // Reset in the middle of data bit 4; the tail of the frame is all ones.
    rises_before = rises;
    fork
      send_byte(8'hF0, 1'b1, 1'b0);
      begin
        repeat (5 * BIT + BIT/2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("abort_rdy", rdy, 0);
        check("abort_rx_data", rx_data, 8'hFF);
      end
    join
    repeat (3 * BIT) @(negedge clk);
    check("abort_no_pulse", rises - rises_before, 0);
    send_byte(8'h55, 1'b1, 1'b1);
    repeat (2 * BIT) @(negedge clk);
    drain("drain_55");
    check("after_abort_pulses", rises - rises_before, 1);

    // Continuous random traffic.
    rises_before = rises;
    for (int i = 0; i < 300; i++) begin
      send_byte(8'($urandom_range(0, 255)), 1'b1, 1'b1);
    end
    repeat (2 * BIT) @(negedge clk);
    drain("drain_random");
    check("random_pulses", rises - rises_before, 300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
